// File: rtl/lc_pkg.sv
// Shared types and helpers for the multi-track level-crossing controller.
package lc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StA1,
    StAbA,
    StBLast,
    StB1,
    StAbB,
    StALast
  } wheel_state_e;

  typedef enum logic [1:0] {
    GsOpen,
    GsWarn,
    GsClosed,
    GsClearing
  } gate_state_e;

  // At least one bit so single-cycle phases still get a legal timer.
  function automatic int unsigned timer_width(int unsigned warn_cycles,
                                              int unsigned clear_cycles);
    int unsigned m;
    m = (warn_cycles > clear_cycles) ? warn_cycles : clear_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lc_wheel_fsm.sv
// Per-track wheel direction detector plus saturating occupancy counter.
module lc_wheel_fsm
  import lc_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sens_a,
  input  logic             sens_b,
  output logic             a2b_pulse,
  output logic             b2a_pulse,
  output logic [CNT_W-1:0] count,
  output logic             cnt_err
);

  wheel_state_e     state_q, state_d;
  logic             a2b_done, b2a_done;
  logic             a2b_done_q, b2a_done_q;
  logic             a2b_pulse_q, b2a_pulse_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       key;

  assign key = {sens_a, sens_b};

  always_comb begin
    state_d  = state_q;
    a2b_done = 1'b0;
    b2a_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key == 2'b10)      state_d = StA1;
        else if (key == 2'b01) state_d = StB1;
      end
      StA1, StAbA, StBLast: begin
        // Once A was seen first, the state simply tracks the current key.
        unique case (key)
          2'b10: state_d = StA1;
          2'b11: state_d = StAbA;
          2'b01: state_d = StBLast;
          default: begin
            state_d  = StIdle;
            a2b_done = (state_q == StBLast);
          end
        endcase
      end
      StB1, StAbB, StALast: begin
        unique case (key)
          2'b01: state_d = StB1;
          2'b11: state_d = StAbB;
          2'b10: state_d = StALast;
          default: begin
            state_d  = StIdle;
            b2a_done = (state_q == StALast);
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_err = (a2b_pulse_q && (count_q == '1)) || (b2a_pulse_q && (count_q == '0));

  always_comb begin
    count_d = count_q;
    if (a2b_pulse_q && (count_q != '1)) count_d = count_q + CNT_W'(1);
    if (b2a_pulse_q && (count_q != '0)) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      a2b_done_q  <= 1'b0;
      b2a_done_q  <= 1'b0;
      a2b_pulse_q <= 1'b0;
      b2a_pulse_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a2b_done_q  <= a2b_done;
      b2a_done_q  <= b2a_done;
      a2b_pulse_q <= a2b_done_q;
      b2a_pulse_q <= b2a_done_q;
      count_q     <= count_d;
    end
  end

  assign a2b_pulse = a2b_pulse_q;
  assign b2a_pulse = b2a_pulse_q;
  assign count     = count_q;

endmodule

// File: rtl/level_crossing_ctrl_n.sv
// Multi-track level-crossing controller: per-track wheel counters feeding a
// shared timed gate FSM with a sticky count-error fault.
module level_crossing_ctrl_n
  import lc_pkg::*;
#(
  parameter int unsigned N_TRACKS     = 2,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned WARN_CYCLES  = 16,
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_TRACKS-1:0]       sens_a,
  input  logic [N_TRACKS-1:0]       sens_b,
  output logic [N_TRACKS-1:0]       a2b_pulse,
  output logic [N_TRACKS-1:0]       b2a_pulse,
  output logic [N_TRACKS*CNT_W-1:0] occ_count,
  output logic [N_TRACKS-1:0]       occupied,
  output logic                      gate_open,
  output logic                      gate_warn,
  output logic                      fault
);

  localparam int unsigned TimerW = timer_width(WARN_CYCLES, CLEAR_CYCLES);
  localparam logic [TimerW-1:0] WarnLoad  = TimerW'(WARN_CYCLES - 1);
  localparam logic [TimerW-1:0] ClearLoad = TimerW'(CLEAR_CYCLES - 1);

  logic [N_TRACKS-1:0] trk_err;
  logic                any_occ;
  logic                fault_q, fault_d;
  gate_state_e         state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  for (genvar i = 0; i < N_TRACKS; i++) begin : g_track
    lc_wheel_fsm #(
      .CNT_W(CNT_W)
    ) u_wheel (
      .Clk      (Clk),
      .Reset    (Reset),
      .sens_a   (sens_a[i]),
      .sens_b   (sens_b[i]),
      .a2b_pulse(a2b_pulse[i]),
      .b2a_pulse(b2a_pulse[i]),
      .count    (occ_count[i*CNT_W +: CNT_W]),
      .cnt_err  (trk_err[i])
    );
    assign occupied[i] = |occ_count[i*CNT_W +: CNT_W];
  end

  assign any_occ = |occupied;
  assign fault_d = fault_q | (|trk_err);
  assign fault   = fault_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    gate_open = 1'b1;
    gate_warn = 1'b0;
    unique case (state_q)
      GsOpen: begin
        if (any_occ || fault_q) begin
          state_d = GsWarn;
          timer_d = WarnLoad;
        end
      end
      GsWarn: begin
        // Committed once started: a track clearing early does not abort closing.
        gate_warn = 1'b1;
        if (timer_q == '0) state_d = GsClosed;
        else               timer_d = timer_q - TimerW'(1);
      end
      GsClosed: begin
        gate_open = 1'b0;
        gate_warn = 1'b1;
        if (!any_occ && !fault_q) begin
          state_d = GsClearing;
          timer_d = ClearLoad;
        end
      end
      GsClearing: begin
        gate_open = 1'b0;
        gate_warn = 1'b1;
        if (any_occ || fault_q) state_d = GsClosed;
        else if (timer_q == '0) state_d = GsOpen;
        else                    timer_d = timer_q - TimerW'(1);
      end
      default: state_d = GsClosed;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= GsOpen;
      timer_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_level_crossing_ctrl_n.sv
// Self-checking bench: abstract per-cycle model of track passages, counters and
// gate timing, compared against the DUT on every falling edge.
module tb_level_crossing_ctrl_n;

  localparam int NT = 2;
  localparam int CW = 4;
  localparam int WC = 16;
  localparam int CC = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [NT-1:0]     sens_a = '0;
  logic [NT-1:0]     sens_b = '0;
  logic [NT-1:0]     a2b_pulse, b2a_pulse, occupied;
  logic [NT*CW-1:0]  occ_count;
  logic              gate_open, gate_warn, fault;

  level_crossing_ctrl_n #(
    .N_TRACKS    (NT),
    .CNT_W       (CW),
    .WARN_CYCLES (WC),
    .CLEAR_CYCLES(CC)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .sens_a   (sens_a),
    .sens_b   (sens_b),
    .a2b_pulse(a2b_pulse),
    .b2a_pulse(b2a_pulse),
    .occ_count(occ_count),
    .occupied (occupied),
    .gate_open(gate_open),
    .gate_warn(gate_warn),
    .fault    (fault)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int n_a2b0 = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a passage is a direction (first sensor hit from rest) and the last
  // non-idle key; it counts when the far sensor alone was last before rest.
  int       m_dir[NT];      // 0 none, 1 A first, 2 B first
  logic [1:0] m_prev[NT];
  bit       m_pend_ab[NT], m_pend_ba[NT], m_ab[NT], m_ba[NT];
  int       m_cnt[NT];
  bit       m_fault;
  int       m_phase;        // 0 open, 1 warning, 2 closed, 3 clearing
  int       m_t0;
  int       cyc = 0;
  bit       m_occ, m_err;
  logic [1:0] m_key;

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      for (int t = 0; t < NT; t++) begin
        m_dir[t] = 0; m_prev[t] = 2'b00; m_cnt[t] = 0;
        m_pend_ab[t] = 0; m_pend_ba[t] = 0; m_ab[t] = 0; m_ba[t] = 0;
      end
      m_fault = 0;
      m_phase = 0;
      m_t0 = 0;
    end else begin
      m_occ = 0;
      for (int t = 0; t < NT; t++) if (m_cnt[t] != 0) m_occ = 1;
      case (m_phase)
        0: if (m_occ || m_fault) begin m_phase = 1; m_t0 = cyc; end
        1: if (cyc - m_t0 == WC) m_phase = 2;
        2: if (!m_occ && !m_fault) begin m_phase = 3; m_t0 = cyc; end
        default: begin
          if (m_occ || m_fault) m_phase = 2;
          else if (cyc - m_t0 == CC) m_phase = 0;
        end
      endcase
      m_err = 0;
      for (int t = 0; t < NT; t++) begin
        if (m_ab[t]) begin
          if (m_cnt[t] == CMAX) m_err = 1; else m_cnt[t]++;
        end
        if (m_ba[t]) begin
          if (m_cnt[t] == 0) m_err = 1; else m_cnt[t]--;
        end
      end
      if (m_err) m_fault = 1;
      for (int t = 0; t < NT; t++) begin
        m_ab[t] = m_pend_ab[t];
        m_ba[t] = m_pend_ba[t];
        m_pend_ab[t] = 0;
        m_pend_ba[t] = 0;
        m_key = {sens_a[t], sens_b[t]};
        if (m_dir[t] == 0) begin
          if (m_key == 2'b10) m_dir[t] = 1;
          else if (m_key == 2'b01) m_dir[t] = 2;
          m_prev[t] = m_key;
        end else if (m_key == 2'b00) begin
          m_pend_ab[t] = (m_dir[t] == 1) && (m_prev[t] == 2'b01);
          m_pend_ba[t] = (m_dir[t] == 2) && (m_prev[t] == 2'b10);
          m_dir[t] = 0;
        end else begin
          m_prev[t] = m_key;
        end
      end
    end
  end

  logic [NT*CW-1:0] e_cnt;
  logic [NT-1:0]    e_ab, e_ba, e_occ;

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int t = 0; t < NT; t++) begin
        e_cnt[t*CW +: CW] = CW'(m_cnt[t]);
        e_ab[t] = m_ab[t];
        e_ba[t] = m_ba[t];
        e_occ[t] = (m_cnt[t] != 0);
      end
      check("a2b_pulse", 32'(a2b_pulse), 32'(e_ab));
      check("b2a_pulse", 32'(b2a_pulse), 32'(e_ba));
      check("occ_count", 32'(occ_count), 32'(e_cnt));
      check("occupied", 32'(occupied), 32'(e_occ));
      check("gate_open", 32'(gate_open), 32'(m_phase <= 1));
      check("gate_warn", 32'(gate_warn), 32'(m_phase != 0));
      check("fault", 32'(fault), 32'(m_fault));
      if (a2b_pulse[0]) n_a2b0++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic drive(input int t, input bit a, input bit b, input int n);
    sens_a[t] = a;
    sens_b[t] = b;
    step(n);
  endtask

  task automatic pass_a2b(input int t);
    drive(t, 1, 0, 3); drive(t, 1, 1, 3); drive(t, 0, 1, 3); drive(t, 0, 0, 3);
  endtask

  task automatic pass_b2a(input int t);
    drive(t, 0, 1, 3); drive(t, 1, 1, 3); drive(t, 1, 0, 3); drive(t, 0, 0, 3);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    check("rst_open", 32'(gate_open), 32'd1);
    check("rst_warn", 32'(gate_warn), 32'd0);
    check("rst_occ", 32'(occ_count), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
  endtask

  task automatic cycles_until_open(input bit val, input int limit, output int n);
    n = 0;
    while (gate_open !== val && n < limit) begin
      @(negedge Clk);
      n++;
    end
  endtask

  int n;

  initial begin
    @(negedge Clk);
    chk_en = 1'b1;
    do_reset();
    step(3);

    // Single A-to-B passage on track 0 closes the gate after the warning.
    pass_a2b(0);
    check("occ0_after_a2b", 32'(occ_count[CW-1:0]), 32'd1);
    check("one_a2b_pulse", 32'(n_a2b0), 32'd1);
    n = 0;
    while (gate_warn !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
    check("warn_latency", 32'(n), 32'd1);
    cycles_until_open(0, 40, n);
    check("warn_to_close", 32'(n), 32'(WC));

    // Reverse passage empties track 0; occupied falling to open is CLEAR_CYCLES+1.
    pass_b2a(0);
    check("occ0_after_b2a", 32'(occupied[0]), 32'd0);
    cycles_until_open(1, 60, n);
    check("clear_to_open", 32'(n), 32'(CC + 1));

    // Track 1 arrives mid-clearing: gate must fall back to closed and retime.
    pass_a2b(0);
    cycles_until_open(0, 60, n);
    check("closed_again", 32'(gate_open), 32'd0);
    pass_b2a(0);
    step(10);
    pass_a2b(1);
    check("still_closed", 32'(gate_open), 32'd0);
    step(40);
    check("held_closed", 32'(gate_open), 32'd0);
    pass_b2a(1);
    cycles_until_open(1, 60, n);
    check("reclear_to_open", 32'(n), 32'(CC + 1));

    // Aborted and reversed movements leave counters alone.
    drive(0, 1, 0, 2); drive(0, 0, 0, 3);
    drive(0, 1, 0, 2); drive(0, 1, 1, 2); drive(0, 1, 0, 2); drive(0, 0, 0, 3);
    check("abort_occ", 32'(occ_count), 32'd0);
    check("abort_open", 32'(gate_open), 32'd1);

    // Underflow sets the sticky fault; gate closes and stays closed.
    pass_b2a(0);
    check("underflow_fault", 32'(fault), 32'd1);
    check("underflow_occ", 32'(occ_count[CW-1:0]), 32'd0);
    cycles_until_open(0, 40, n);
    pass_a2b(1);
    pass_b2a(1);
    step(50);
    check("fault_stuck_closed", 32'(gate_open), 32'd0);
    check("fault_stuck_warn", 32'(gate_warn), 32'd1);

    // Reset clears the fault mid-operation; then overflow track 1.
    do_reset();
    for (int i = 0; i < 16; i++) pass_a2b(1);
    check("sat_occ1", 32'(occ_count[2*CW-1:CW]), 32'd15);
    check("sat_fault", 32'(fault), 32'd1);
    step(5);

    do_reset();
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
